// File: rtl/cc_serializer_pkg.sv
// Shared types and entry-layout helpers for the cache-line R-channel serializer.
// Entry layout, LSB first: line, byte offset, mode bit, id.
package cc_serializer_pkg;

    typedef enum logic {
        MODE_INCR = 1'b0,
        MODE_WRAP = 1'b1
    } burst_mode_e;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_LINE_W = 512;
    localparam int DEF_ID_W   = 4;

    function automatic int off_w(int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int offset_lsb(int line_w);
        return line_w;
    endfunction

    function automatic int mode_pos(int line_w);
        return line_w + off_w(line_w);
    endfunction

    function automatic int id_lsb(int line_w);
        return line_w + off_w(line_w) + 1;
    endfunction

    function automatic int entry_w(int line_w, int id_w);
        return id_w + 1 + off_w(line_w) + line_w;
    endfunction

endpackage

// File: rtl/cc_beat_idx_gen.sv
// Next word index / beat count and last-beat flag for the serializer.
// WRAP ends on the beat count, INCR ends on the top word of the line.
module cc_beat_idx_gen
    import cc_serializer_pkg::*;
#(
    parameter int BEATS = 8,
    parameter int IDX_W = 3
) (
    input  logic             load,
    input  burst_mode_e      mode,
    input  logic [IDX_W-1:0] start,
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] cnt,
    output logic [IDX_W-1:0] nxt_idx,
    output logic [IDX_W-1:0] nxt_cnt,
    output logic             nxt_last
);

    localparam logic [IDX_W-1:0] TOP = IDX_W'(BEATS - 1);

    always_comb begin
        nxt_idx  = idx + 1'b1;
        nxt_cnt  = cnt + 1'b1;
        nxt_last = 1'b0;
        if (load) begin
            nxt_idx = start;
            nxt_cnt = '0;
        end
        unique case (mode)
            MODE_WRAP: nxt_last = (nxt_cnt == TOP);
            MODE_INCR: nxt_last = (nxt_idx == TOP);
            default:   nxt_last = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_line_serializer.sv
// Streams cache lines popped from a FWFT FIFO as AXI R-channel beats.
// Supports WRAP / INCR ordering and back-to-back lines without bubbles.
module cc_line_serializer
    import cc_serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = DEF_LINE_W,
    parameter int ID_W   = DEF_ID_W,
    localparam int BEATS    = LINE_W / DATA_W,
    localparam int OFFSET_W = off_w(LINE_W),
    localparam int ENTRY_W  = entry_w(LINE_W, ID_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty_i,
    input  logic               fifo_aempty_i,
    input  logic [ENTRY_W-1:0] fifo_rdata_i,
    output logic               fifo_rden_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic [ID_W-1:0]    rid_o,
    output logic               rlast_o,
    output logic               rvalid_o,
    input  logic               rready_i
);

    localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_LSB = $clog2(DATA_W / 8);
    localparam int OFF_LSB  = offset_lsb(LINE_W);
    localparam int MODE_POS = mode_pos(LINE_W);
    localparam int ID_LSB   = id_lsb(LINE_W);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q;
    logic [LINE_W-1:0] line_q;
    logic [ID_W-1:0]   id_q;
    burst_mode_e       mode_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              last_q;

    logic [LINE_W-1:0]   f_line;
    logic [OFFSET_W-1:0] f_off;
    burst_mode_e         f_mode;
    logic [ID_W-1:0]     f_id;
    logic [IDX_W-1:0]    f_start;

    logic             beat_ok;
    logic             load;
    burst_mode_e      gen_mode;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] nxt_cnt;
    logic             nxt_last;
    logic             unused_ok;

    assign f_line  = fifo_rdata_i[LINE_W-1:0];
    assign f_off   = fifo_rdata_i[OFF_LSB +: OFFSET_W];
    assign f_mode  = burst_mode_e'(fifo_rdata_i[MODE_POS]);
    assign f_id    = fifo_rdata_i[ID_LSB +: ID_W];
    // Byte bits below the beat boundary do not select a word.
    assign f_start = f_off[WORD_LSB +: IDX_W];

    assign unused_ok = ^{fifo_aempty_i, f_off};

    assign rvalid_o = (state_q == ST_SEND);
    assign rlast_o  = last_q;
    assign rid_o    = id_q;
    assign rdata_o  = line_q[idx_q * DATA_W +: DATA_W];

    assign beat_ok = rvalid_o & rready_i;

    always_comb begin
        load = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE): load = 1'b1;
            (state_q == ST_SEND): load = beat_ok & last_q;
            default:              load = 1'b0;
        endcase
        load = load & ~fifo_empty_i & rst_n;
    end

    assign fifo_rden_o = load;
    assign gen_mode    = load ? f_mode : mode_q;

    cc_beat_idx_gen #(
        .BEATS (BEATS),
        .IDX_W (IDX_W)
    ) u_idx (
        .load     (load),
        .mode     (gen_mode),
        .start    (f_start),
        .idx      (idx_q),
        .cnt      (cnt_q),
        .nxt_idx  (nxt_idx),
        .nxt_cnt  (nxt_cnt),
        .nxt_last (nxt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            id_q    <= '0;
            mode_q  <= MODE_INCR;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            state_q <= ST_SEND;
            line_q  <= f_line;
            id_q    <= f_id;
            mode_q  <= f_mode;
            idx_q   <= nxt_idx;
            cnt_q   <= nxt_cnt;
            last_q  <= nxt_last;
        end else if (beat_ok) begin
            if (last_q) begin
                state_q <= ST_IDLE;
                last_q  <= 1'b0;
            end else begin
                idx_q  <= nxt_idx;
                cnt_q  <= nxt_cnt;
                last_q <= nxt_last;
            end
        end
    end

endmodule
